// File: rtl/fg_pkg.sv
// Shared definitions for the multi-channel function generator:
// waveform modes, register offsets, global addresses and CTRL bit layout.
package fg_pkg;

    typedef enum logic [1:0] {
        SQUARE = 2'd0,
        SAW    = 2'd1,
        TRI    = 2'd2,
        TABLE  = 2'd3
    } fg_mode_e;

    typedef struct packed {
        logic     invert;
        fg_mode_e mode;
        logic     enable;
    } fg_ctrl_t;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_FREQ  = 2'd1;
    localparam logic [1:0] REG_DUTY  = 2'd2;
    localparam logic [1:0] REG_PHASE = 2'd3;

    localparam logic [7:0] ADDR_PRESCALE = 8'hF0;
    localparam logic [7:0] ADDR_SYNC     = 8'hF1;
    localparam logic [7:0] ADDR_TABLE    = 8'h80;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_INV_BIT  = 3;

    // Word address of a per-channel register: four words per channel.
    function automatic logic [7:0] ch_addr(input int unsigned ch, input logic [1:0] off);
        logic [31:0] ch_v;
        ch_v = ch;
        return {ch_v[5:0], off};
    endfunction

endpackage

// File: rtl/fg_channel.sv
// One generator channel: phase accumulator, wrap detection and waveform
// shaping. The wavetable value for the current phase is supplied by the top.
module fg_channel
    import fg_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             emit_i,
    input  fg_ctrl_t         ctrl_i,
    input  logic [ACC_W-1:0] freq_i,
    input  logic [OUT_W-1:0] duty_i,
    input  logic             load_i,
    input  logic [ACC_W-1:0] load_val_i,
    input  logic [OUT_W-1:0] table_val_i,
    output logic [ACC_W-1:0] acc_o,
    output logic [OUT_W-1:0] sample_o,
    output logic             sync_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             wrap_q, wrap_d;
    logic [OUT_W-1:0] sample_q;
    logic             sync_q;
    logic [ACC_W:0]   sum;
    logic [OUT_W-1:0] p, t, shaped, wave;

    assign p = acc_q[ACC_W-1 -: OUT_W];
    assign t = acc_q[ACC_W-2 -: OUT_W];

    // Accumulator advance; a direct load (PHASE or SYNC) overrides the tick.
    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, freq_i};
        acc_d  = acc_q;
        wrap_d = 1'b0;
        if (load_i) begin
            acc_d = load_val_i;
        end else if (tick_i && ctrl_i.enable) begin
            acc_d  = sum[ACC_W-1:0];
            wrap_d = sum[ACC_W];
        end
    end

    // Waveform selection from the current phase, then optional inversion.
    always_comb begin
        shaped = '0;
        case (ctrl_i.mode)
            SQUARE:  shaped = (p < duty_i) ? '1 : '0;
            SAW:     shaped = p;
            TRI:     shaped = acc_q[ACC_W-1] ? ~t : t;
            TABLE:   shaped = table_val_i;
            default: shaped = '0;
        endcase
        if (!ctrl_i.enable) begin
            wave = '0;
        end else if (ctrl_i.invert) begin
            wave = ~shaped;
        end else begin
            wave = shaped;
        end
    end

    // Accumulator and pending wrap update every cycle; sample/sync only on emit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            wrap_q   <= 1'b0;
            sample_q <= '0;
            sync_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            wrap_q <= wrap_d;
            if (emit_i) begin
                sample_q <= wave;
            end
            sync_q <= emit_i & wrap_q & ctrl_i.enable;
        end
    end

    assign acc_o    = acc_q;
    assign sample_o = sample_q;
    assign sync_o   = sync_q;

endmodule

// File: rtl/multi_function_generator.sv
// N-channel DDS function generator: register port, shared prescaler,
// optional shared wavetable (build with FG_TABLE_EN) and channel array.
module multi_function_generator
    import fg_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int ACC_W       = 16,
    parameter int OUT_W       = 8,
    parameter int PRESCALE_W  = 16,
    parameter int TABLE_DEPTH = 32
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      cfg_stb,
    input  logic                      cfg_we,
    input  logic [7:0]                cfg_addr,
    input  logic [31:0]               cfg_wdata,
    output logic [31:0]               cfg_rdata,
    output logic                      cfg_ack,
    output logic [CHANNELS*OUT_W-1:0] sample_o,
    output logic                      sample_valid_o,
    output logic [CHANNELS-1:0]       sync_o
);

    localparam int TBL_AW = $clog2(TABLE_DEPTH);

    fg_ctrl_t          ctrl_q  [CHANNELS];
    logic [ACC_W-1:0]  freq_q  [CHANNELS];
    logic [OUT_W-1:0]  duty_q  [CHANNELS];
    logic [ACC_W-1:0]  acc_w   [CHANNELS];
    logic [OUT_W-1:0]  tbl_val [CHANNELS];
    logic [OUT_W-1:0]  samp_w  [CHANNELS];
    logic [CHANNELS-1:0] load;

    logic [PRESCALE_W-1:0] prescale_q, cnt_q;
    logic        tick, any_en, emit_q, valid_q, ack_q, wr, rd;
    logic [31:0] rdata_q, rdata_d;

    assign wr   = cfg_stb & cfg_we;
    assign rd   = cfg_stb & ~cfg_we;
    assign tick = (cnt_q == prescale_q);

`ifdef FG_TABLE_EN
    logic [OUT_W-1:0] table_q [TABLE_DEPTH];
    logic             tbl_hit;
    assign tbl_hit = (cfg_addr >= ADDR_TABLE) && (cfg_addr < ADDR_TABLE + 8'(TABLE_DEPTH));

    // Wavetable storage is deliberately left out of reset.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && wr && tbl_hit) begin
            table_q[cfg_addr[TBL_AW-1:0]] <= cfg_wdata[OUT_W-1:0];
        end
    end
`endif

    // Per-channel configuration register writes.
    always_ff @(posedge wb_clk_i) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (wb_rst_i) begin
                ctrl_q[c] <= '0;
                freq_q[c] <= '0;
                duty_q[c] <= '0;
            end else if (wr) begin
                if (cfg_addr == ch_addr(c, REG_CTRL)) begin
                    ctrl_q[c] <= '{invert: cfg_wdata[CTRL_INV_BIT],
                                   mode:   fg_mode_e'(cfg_wdata[CTRL_MODE_LSB +: 2]),
                                   enable: cfg_wdata[CTRL_EN_BIT]};
                end
                if (cfg_addr == ch_addr(c, REG_FREQ)) freq_q[c] <= cfg_wdata[ACC_W-1:0];
                if (cfg_addr == ch_addr(c, REG_DUTY)) duty_q[c] <= cfg_wdata[OUT_W-1:0];
            end
        end
    end

    // Prescaler: counts up to PRESCALE, reloads on tick or on a PRESCALE write.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            prescale_q <= '0;
            cnt_q      <= '0;
        end else if (wr && cfg_addr == ADDR_PRESCALE) begin
            prescale_q <= cfg_wdata[PRESCALE_W-1:0];
            cnt_q      <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Direct accumulator loads and channel-enable summary.
    always_comb begin
        any_en = 1'b0;
        load   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            any_en  = any_en | ctrl_q[c].enable;
            load[c] = wr && (cfg_addr == ADDR_SYNC || cfg_addr == ch_addr(c, REG_PHASE));
        end
    end

    // Read mux over all mapped registers; unmapped addresses return zero.
    always_comb begin
        rdata_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cfg_addr == ch_addr(c, REG_CTRL))  rdata_d = 32'(ctrl_q[c]);
            if (cfg_addr == ch_addr(c, REG_FREQ))  rdata_d = 32'(freq_q[c]);
            if (cfg_addr == ch_addr(c, REG_DUTY))  rdata_d = 32'(duty_q[c]);
            if (cfg_addr == ch_addr(c, REG_PHASE)) rdata_d = 32'(acc_w[c]);
        end
        if (cfg_addr == ADDR_PRESCALE) rdata_d = 32'(prescale_q);
`ifdef FG_TABLE_EN
        if (tbl_hit) rdata_d = 32'(table_q[cfg_addr[TBL_AW-1:0]]);
`endif
    end

    // Ack/read data one cycle after strobe; emit/valid pipeline behind the tick.
    // With every channel disabled no sample frames are announced.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            emit_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            ack_q   <= cfg_stb;
            rdata_q <= rd ? rdata_d : '0;
            emit_q  <= tick & any_en;
            valid_q <= emit_q;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
`ifdef FG_TABLE_EN
        assign tbl_val[c] = table_q[acc_w[c][ACC_W-1 -: TBL_AW]];
`else
        assign tbl_val[c] = '0;
`endif
        fg_channel #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_ch (
            .clk_i       (wb_clk_i),
            .rst_i       (wb_rst_i),
            .tick_i      (tick),
            .emit_i      (emit_q),
            .ctrl_i      (ctrl_q[c]),
            .freq_i      (freq_q[c]),
            .duty_i      (duty_q[c]),
            .load_i      (load[c]),
            .load_val_i  ((cfg_addr == ADDR_SYNC) ? '0 : cfg_wdata[ACC_W-1:0]),
            .table_val_i (tbl_val[c]),
            .acc_o       (acc_w[c]),
            .sample_o    (samp_w[c]),
            .sync_o      (sync_o[c])
        );
        assign sample_o[c*OUT_W +: OUT_W] = samp_w[c];
    end

    assign cfg_ack        = ack_q;
    assign cfg_rdata      = rdata_q;
    assign sample_valid_o = valid_q;

endmodule

// File: tb/tb_multi_function_generator.sv
// Directed bench for multi_function_generator (default parameters).
// The wavetable section follows FG_TABLE_EN.
module tb_multi_function_generator;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cfg_stb, cfg_we;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata;
    logic        cfg_ack;
    logic [15:0] sample_o;
    logic        sample_valid_o;
    logic [1:0]  sync_o;

    int tests = 0;
    int fails = 0;

    multi_function_generator dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .cfg_stb        (cfg_stb),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_rdata      (cfg_rdata),
        .cfg_ack        (cfg_ack),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .sync_o         (sync_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge wb_clk_i);
        cfg_stb = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge wb_clk_i);
        cfg_stb = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        @(negedge wb_clk_i);
        cfg_stb = 1'b1; cfg_we = 1'b0; cfg_addr = a;
        @(negedge wb_clk_i);
        cfg_stb = 1'b0;
        chk({tag, "_ack"}, 32'(cfg_ack), 32'd1);
        chk(tag, cfg_rdata, exp);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge wb_clk_i);
            n++;
        end while (!sample_valid_o && n < 200);
        if (!sample_valid_o) chk("valid_timeout", 32'(sample_valid_o), 32'd1);
    endtask

    initial begin
        int n;
        int zeros;
        logic seen;
        logic [7:0] e;

        wb_rst_i = 1'b1; cfg_stb = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        repeat (3) @(negedge wb_clk_i);
        chk("rst_sample", 32'(sample_o), 32'd0);
        chk("rst_valid", 32'(sample_valid_o), 32'd0);
        chk("rst_sync", 32'(sync_o), 32'd0);
        chk("rst_ack", 32'(cfg_ack), 32'd0);
        wb_rst_i = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge wb_clk_i);
            seen = seen | sample_valid_o;
        end
        chk("idle_no_valid", 32'(seen), 32'd0);
        rd("rd_freq0_rst", 8'h01, 32'd0);
        @(negedge wb_clk_i);
        chk("ack_one_cycle", 32'(cfg_ack), 32'd0);
        rd("rd_prescale_rst", 8'hF0, 32'd0);

        // ch0 sawtooth, prescale 3
        wr(8'hF0, 32'd3);
        wr(8'h01, 32'h1000);
        wr(8'h00, 32'h3);
        for (int k = 0; k < 17; k++) begin
            wait_valid(n);
            if (k > 0) chk("saw_interval", 32'(n), 32'd4);
            e = 8'((k + 1) * 16);
            chk("saw_sample", 32'(sample_o[7:0]), 32'(e));
            chk("saw_sync", 32'(sync_o), (k == 15) ? 32'd1 : 32'd0);
        end
        chk("saw_ch1_off", 32'(sample_o[15:8]), 32'd0);
        rd("rd_freq0", 8'h01, 32'h1000);
        rd("rd_unmapped", 8'h50, 32'd0);
        rd("rd_sync", 8'hF1, 32'd0);
        rd("rd_prescale", 8'hF0, 32'd3);

        // ch1 inverted square, duty 0x40, prescale 0
        wr(8'h00, 32'h0);
        wr(8'hF0, 32'd0);
        wr(8'h06, 32'h40);
        wr(8'h05, 32'h0400);
        wr(8'h04, 32'h9);
        zeros = 0;
        for (int k = 1; k <= 64; k++) begin
            wait_valid(n);
            if (k > 1) chk("sq_interval", 32'(n), 32'd1);
            e = ((k % 64) < 16) ? 8'h00 : 8'hFF;
            chk("sq_sample", 32'(sample_o[15:8]), 32'(e));
            if (sample_o[15:8] == 8'h00) zeros++;
            if (k == 1) chk("sq_ch0_off", 32'(sample_o[7:0]), 32'd0);
        end
        chk("sq_zero_count", 32'(zeros), 32'd16);
        rd("rd_duty1", 8'h06, 32'h40);

        // ch0 triangle
        wr(8'h04, 32'h0);
        wr(8'h03, 32'h0);
        wr(8'h01, 32'h0800);
        wr(8'h00, 32'h5);
        for (int k = 1; k <= 32; k++) begin
            wait_valid(n);
            if (k < 16)      e = 8'(k * 16);
            else if (k < 32) e = 8'(255 - (k - 16) * 16);
            else             e = 8'h00;
            chk("tri_sample", 32'(sample_o[7:0]), 32'(e));
        end

        // mode 3: wavetable lookup, or constant 0 without the table
        wr(8'h00, 32'h0);
`ifdef FG_TABLE_EN
        for (int i = 0; i < 32; i++) wr(8'(8'h80 + i), 32'(i * 8));
        rd("rd_table5", 8'h85, 32'h28);
        wr(8'h03, 32'h0);
        wr(8'h01, 32'h0800);
        wr(8'h00, 32'h7);
        for (int k = 1; k <= 8; k++) begin
            wait_valid(n);
            chk("table_sample", 32'(sample_o[7:0]), 32'(k * 8));
        end
`else
        wr(8'h85, 32'h28);
        rd("rd_table_unmapped", 8'h85, 32'd0);
        wr(8'h00, 32'h7);
        wait_valid(n);
        wait_valid(n);
        chk("table_off_sample", 32'(sample_o[7:0]), 32'd0);
`endif

        // SYNC landing on a tick, with a pending wrap set up by a PHASE load
        wr(8'h00, 32'h0);
        wr(8'hF0, 32'd3);
        wr(8'h03, 32'h0);
        wr(8'h01, 32'h1000);
        wr(8'h07, 32'h0);
        wr(8'h05, 32'h3000);
        wr(8'h04, 32'h3);
        wr(8'h00, 32'h3);
        repeat (3) wait_valid(n);
        @(negedge wb_clk_i);
        cfg_stb = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h03; cfg_wdata = 32'hF000;
        @(negedge wb_clk_i);
        cfg_addr = 8'hF1; cfg_wdata = 32'h1234;
        @(negedge wb_clk_i);
        cfg_stb = 1'b0; cfg_we = 1'b0;
        wait_valid(n);
        chk("sync_latency", 32'(n), 32'd1);
        chk("sync_sample", 32'(sample_o), 32'h0000);
        chk("sync_no_wrap", 32'(sync_o), 32'd0);
        wait_valid(n);
        chk("sync_next_interval", 32'(n), 32'd4);
        chk("sync_next_sample", 32'(sample_o), 32'h3010);

        // reset during an access drops it and clears state
        @(negedge wb_clk_i);
        cfg_stb = 1'b1; cfg_we = 1'b1; cfg_addr = 8'h01; cfg_wdata = 32'h5555;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        cfg_stb = 1'b0; cfg_we = 1'b0;
        chk("rst_mid_ack", 32'(cfg_ack), 32'd0);
        chk("rst_mid_sample", 32'(sample_o), 32'd0);
        chk("rst_mid_valid", 32'(sample_valid_o), 32'd0);
        wb_rst_i = 1'b0;
        rd("rd_freq0_after_rst", 8'h01, 32'd0);
        rd("rd_ctrl0_after_rst", 8'h00, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
